hazard_stall_unit: RTL and testbench
====================================

// Module: hazard_stall_unit
// PURPOSE
//  Decode-stage hazard detector that produces the stall that zeroes ID control/competition signals before ID/EX.
//  Detects load-use and branch-operand hazards, and sequences multi-cycle SAD/min-find ops.
//  While a find op is in flight, the unit holds off following instructions until done or timeout.
//  Drives PC/IF-ID write enables.
// PARAMETERS
//  FIND_MAX_CYCLES  64  cycles in FIND_BUSY before forced exit with timeout; legal range 2..65535
//  CNT_W            16  width of find-cycle counter and stats counter
// PORTS
//  Clk            in   1  rising-edge clock
//  Reset_n        in   1  async active-low reset
//  IF_ID_Rs       in   5  rs of instr in ID
//  IF_ID_Rt       in   5  rt of instr in ID
//  IF_ID_UsesRt   in   1  ID instr reads rt as source
//  IF_ID_Branch   in   1  ID instr is branch resolved in ID
//  IF_ID_Find     in   1  ID instr starts SAD/min-find op
//  ID_EX_MemRead  in   1  EX instr is a load
//  ID_EX_RegWrite in   1  EX instr writes a register
//  ID_EX_Dst      in   5  EX instr destination register
//  Flush          in   1  branch-taken flush of IF/ID
//  find_done      in   1  find engine completion pulse
//  stats_clr      in   1  sync clear of stall_count
//  stall          out  1  bubble select to the stall mux (1 = zero all ID controls)
//  PCWrite        out  1  PC load enable
//  IF_ID_Write    out  1  IF/ID load enable
//  find_go        out  1  1-cycle start pulse to find engine
//  find_timeout   out  1  sticky: a find op hit FIND_MAX_CYCLES
//  stall_cause    out  2  0 none, 1 load-use, 2 branch, 3 find-busy
//  stall_count    out  CNT_W  stall cycles counted (see CONFIGURATION)
// BEHAVIOUR
//  Terms (all comparisons ignore register 0):
//   src_hit = (ID_EX_Dst==IF_ID_Rs) | (IF_ID_UsesRt & ID_EX_Dst==IF_ID_Rt)
//   load_use = ID_EX_MemRead & src_hit & ~IF_ID_Branch
//   br_haz = IF_ID_Branch & ID_EX_RegWrite & src_hit
//  For loads, ID_EX_Dst is rt.
//  FSM states IDLE, BR_LOAD2, FIND_BUSY; one-hot or binary is free.
//   IDLE: br_haz -> stall=1, cause 2; go to BR_LOAD2 if ID_EX_MemRead, else stay.
//         else load_use -> stall=1, cause 1; stay.
//         else IF_ID_Find -> stall=0, find_go=1, cnt<=0; go to FIND_BUSY.
//   BR_LOAD2: stall=1, cause 2; always -> IDLE (load result now forwardable in MEM).
//   FIND_BUSY: stall=1, cause 3, cnt++.
//         find_done -> IDLE.
//         else cnt==FIND_MAX_CYCLES-1 -> IDLE and set find_timeout.
//         find_done and timeout in the same cycle: done wins, no timeout.
//  PCWrite = IF_ID_Write = ~stall. Outputs are combinational from state+inputs (same-cycle response).
//  Flush=1: stall forced 0, find_go suppressed.
//   BR_LOAD2 -> IDLE. FIND_BUSY is not aborted: the find op is already in EX.
//   In FIND_BUSY, Flush only forces stall 0 for that cycle; the counter keeps running.
//  find_go never asserts in two consecutive cycles. No find_go while stall=1.
//  Reset (async, Reset_n=0): state IDLE, cnt 0, find_timeout 0, stall_count 0.
//   While reset is held: stall=0, PCWrite=0, IF_ID_Write=0, find_go=0, stall_cause=0.
//   Reset in FIND_BUSY abandons the op; a late find_done in IDLE is ignored.
// CONFIGURATION
//  HAZARD_STATS_EN defined:
//   stall_count increments on every cycle with stall=1, saturating at all-ones.
//   stats_clr=1 clears it next edge; clear wins over increment.
//  HAZARD_STATS_EN undefined: counter logic absent, stall_count tied to 0, stats_clr ignored.
// TESTING
//  1 Load-use: ID_EX_MemRead=1, Dst=5, IF_ID_Rs=5 -> stall=1, PCWrite=0, cause=1 for exactly 1 cycle.
//  2 Reg-zero: same as 1 but Dst=0 -> stall=0.
//  3 Branch after ALU op: Branch=1, RegWrite=1, Dst=Rt=7, UsesRt=1 -> 1 stall cycle.
//    Branch after load on the same register -> 2 stall cycles; 2nd is BR_LOAD2.
//    Flush during BR_LOAD2 -> stall=0 that cycle.
//  4 Find: IF_ID_Find=1 -> find_go 1 cycle, stall=0.
//    find_done 10 cycles later -> stall=1 for exactly 10 cycles, cause=3, no timeout.
//  5 Timeout (FIND_MAX_CYCLES=4), no find_done -> stall high 4 cycles.
//    Then IDLE, find_timeout=1 and sticky until reset. find_done on the 4th cycle -> no timeout.
//  6 Stats (macro on): tests 1+3 -> stall_count=4.
//    stats_clr -> 0. Reset_n low mid-FIND_BUSY -> state IDLE, stall=0, find_timeout=0.
//    Macro off: stall_count stays 0 throughout.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// Decode-stage hazard detector: load-use / branch-operand stalls and SAD/min-find sequencing.
// Define HAZARD_STATS_EN to build the saturating stall_count statistics counter.
module hazard_stall_unit #(
   parameter int unsigned FIND_MAX_CYCLES = 64,
   parameter int unsigned CNT_W           = 16
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic [4:0]       IF_ID_Rs,
   input  logic [4:0]       IF_ID_Rt,
   input  logic             IF_ID_UsesRt,
   input  logic             IF_ID_Branch,
   input  logic             IF_ID_Find,
   input  logic             ID_EX_MemRead,
   input  logic             ID_EX_RegWrite,
   input  logic [4:0]       ID_EX_Dst,
   input  logic             Flush,
   input  logic             find_done,
   input  logic             stats_clr,
   output logic             stall,
   output logic             PCWrite,
   output logic             IF_ID_Write,
   output logic             find_go,
   output logic             find_timeout,
   output logic [1:0]       stall_cause,
   output logic [CNT_W-1:0] stall_count
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      BR_LOAD2  = 2'd1,
      FIND_BUSY = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      CAUSE_NONE = 2'd0,
      CAUSE_LOAD = 2'd1,
      CAUSE_BR   = 2'd2,
      CAUSE_FIND = 2'd3
   } cause_e;

   localparam logic [CNT_W-1:0] FIND_LAST = CNT_W'(FIND_MAX_CYCLES - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q, timeout_d;

   logic src_hit, load_use, br_haz;

   // Register 0 is hard-wired, so a write to it never creates a dependency.
   assign src_hit  = (ID_EX_Dst != 5'd0) &&
                     ((ID_EX_Dst == IF_ID_Rs) || (IF_ID_UsesRt && (ID_EX_Dst == IF_ID_Rt)));
   assign load_use = ID_EX_MemRead & src_hit & ~IF_ID_Branch;
   assign br_haz   = IF_ID_Branch & ID_EX_RegWrite & src_hit;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   // NOTE: every comb output gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
      unique case (state_q)
         IDLE: begin
            // A flushed ID instruction is dead: it may neither stall nor launch a find.
            if (!Flush) begin
               if (br_haz) begin
                  if (ID_EX_MemRead) state_d = BR_LOAD2;
               end else if (!load_use && IF_ID_Find) begin
                  cnt_d   = '0;
                  state_d = FIND_BUSY;
               end
            end
         end
         BR_LOAD2: state_d = IDLE;
         FIND_BUSY: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (find_done) begin
               state_d = IDLE;
            end else if (cnt_q == FIND_LAST) begin
               state_d   = IDLE;
               timeout_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      stall       = 1'b0;
      stall_cause = CAUSE_NONE;
      find_go     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (br_haz) begin
               stall       = 1'b1;
               stall_cause = CAUSE_BR;
            end else if (load_use) begin
               stall       = 1'b1;
               stall_cause = CAUSE_LOAD;
            end else if (IF_ID_Find) begin
               find_go = 1'b1;
            end
         end
         BR_LOAD2: begin
            stall       = 1'b1;
            stall_cause = CAUSE_BR;
         end
         FIND_BUSY: begin
            stall       = 1'b1;
            stall_cause = CAUSE_FIND;
         end
         default: ;
      endcase
      if (Flush || !Reset_n) begin
         stall       = 1'b0;
         stall_cause = CAUSE_NONE;
         find_go     = 1'b0;
      end
   end

   // Enables are also held low while reset is asserted, so the pipeline front end freezes.
   assign PCWrite      = Reset_n & ~stall;
   assign IF_ID_Write  = Reset_n & ~stall;
   assign find_timeout = timeout_q;

`ifdef HAZARD_STATS_EN
   logic [CNT_W-1:0] stall_count_q, stall_count_d;

   always_comb begin
      stall_count_d = stall_count_q;
      if (stats_clr) begin
         stall_count_d = '0;
      end else if (stall && (stall_count_q != {CNT_W{1'b1}})) begin
         stall_count_d = stall_count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) stall_count_q <= '0;
      else          stall_count_q <= stall_count_d;
   end

   assign stall_count = stall_count_q;
`else
   logic stats_clr_unused;
   assign stats_clr_unused = stats_clr;
   assign stall_count      = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: dut_a uses the default find limit, dut_b a limit of 4.
// Both share stimulus; each expected cycle names which instance it checks.
module tb_hazard_stall_unit;

   logic       Clk = 1'b0;
   logic       Reset_n;
   logic [4:0] IF_ID_Rs, IF_ID_Rt, ID_EX_Dst;
   logic       IF_ID_UsesRt, IF_ID_Branch, IF_ID_Find;
   logic       ID_EX_MemRead, ID_EX_RegWrite;
   logic       Flush, find_done, stats_clr;

   logic        stall_a, pcw_a, ifw_a, go_a, to_a;
   logic [1:0]  cause_a;
   logic [15:0] cnt_a;
   logic        stall_b, pcw_b, ifw_b, go_b, to_b;
   logic [1:0]  cause_b;
   logic [15:0] cnt_b;

   hazard_stall_unit dut_a (
      .Clk(Clk), .Reset_n(Reset_n), .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt),
      .IF_ID_UsesRt(IF_ID_UsesRt), .IF_ID_Branch(IF_ID_Branch), .IF_ID_Find(IF_ID_Find),
      .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_Dst(ID_EX_Dst),
      .Flush(Flush), .find_done(find_done), .stats_clr(stats_clr),
      .stall(stall_a), .PCWrite(pcw_a), .IF_ID_Write(ifw_a), .find_go(go_a),
      .find_timeout(to_a), .stall_cause(cause_a), .stall_count(cnt_a)
   );

   hazard_stall_unit #(.FIND_MAX_CYCLES(4)) dut_b (
      .Clk(Clk), .Reset_n(Reset_n), .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt),
      .IF_ID_UsesRt(IF_ID_UsesRt), .IF_ID_Branch(IF_ID_Branch), .IF_ID_Find(IF_ID_Find),
      .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_Dst(ID_EX_Dst),
      .Flush(Flush), .find_done(find_done), .stats_clr(stats_clr),
      .stall(stall_b), .PCWrite(pcw_b), .IF_ID_Write(ifw_b), .find_go(go_b),
      .find_timeout(to_b), .stall_cause(cause_b), .stall_count(cnt_b)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic       sel;
      logic       stall;
      logic       pcw;
      logic [1:0] cause;
      logic       go;
   } exp_t;

   exp_t  sb[$];
   string sb_name[$];
   int    n_checks = 0;
   int    n_pass   = 0;

   function automatic logic [15:0] stat_exp(input int n);
`ifdef HAZARD_STATS_EN
      return 16'(n);
`else
      return 16'(n - n);
`endif
   endfunction

   // Inputs are applied just after a rising edge; the monitor compares on the falling edge.
   task automatic expect_cyc(input string nm, input logic sel, input logic st, input logic pcw,
                             input logic [1:0] ca, input logic go);
      exp_t e;
      e = '{sel: sel, stall: st, pcw: pcw, cause: ca, go: go};
      sb.push_back(e);
      sb_name.push_back(nm);
      @(posedge Clk);
      #1;
   endtask

   exp_t       mon_e;
   string      mon_n;
   logic [5:0] mon_obs, mon_want;

   always @(negedge Clk) begin
      if (sb.size() != 0) begin
         mon_e    = sb.pop_front();
         mon_n    = sb_name.pop_front();
         mon_obs  = mon_e.sel ? {stall_b, pcw_b, ifw_b, cause_b, go_b}
                              : {stall_a, pcw_a, ifw_a, cause_a, go_a};
         mon_want = {mon_e.stall, mon_e.pcw, mon_e.pcw, mon_e.cause, mon_e.go};
         n_checks++;
         if (mon_obs !== mon_want)
            $display("FAIL %s: {stall,pcw,ifw,cause,go} got %b required %b", mon_n, mon_obs, mon_want);
         else
            n_pass++;
      end
   end

   task automatic idle_in();
      IF_ID_Rs = 5'd0; IF_ID_Rt = 5'd0; IF_ID_UsesRt = 1'b0; IF_ID_Branch = 1'b0;
      IF_ID_Find = 1'b0; ID_EX_MemRead = 1'b0; ID_EX_RegWrite = 1'b0; ID_EX_Dst = 5'd0;
      Flush = 1'b0; find_done = 1'b0; stats_clr = 1'b0;
   endtask

   task automatic test_reset();
      idle_in();
      ID_EX_MemRead = 1'b1; ID_EX_RegWrite = 1'b1; ID_EX_Dst = 5'd5; IF_ID_Rs = 5'd5;
      expect_cyc("reset_hold_a", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
      IF_ID_Find = 1'b1;
      expect_cyc("reset_hold_b", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
      n_checks++;
      if (to_a !== 1'b0) $display("FAIL reset_timeout: got %b required 0", to_a);
      else n_pass++;
      n_checks++;
      if (cnt_a !== 16'd0) $display("FAIL reset_count: got %0d required 0", cnt_a);
      else n_pass++;
      Reset_n = 1'b1;
      idle_in();
      expect_cyc("reset_release_idle", 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
   endtask

   task automatic test_load_use();
      idle_in();
      ID_EX_MemRead = 1'b1; ID_EX_RegWrite = 1'b1; ID_EX_Dst = 5'd5; IF_ID_Rs = 5'd5;
      expect_cyc("load_use_stall", 1'b0, 1'b1, 1'b0, 2'd1, 1'b0);
      ID_EX_MemRead = 1'b0; ID_EX_RegWrite = 1'b0; ID_EX_Dst = 5'd0;
      expect_cyc("load_use_release", 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
   endtask

   task automatic test_reg_zero();
      idle_in();
      ID_EX_MemRead = 1'b1; ID_EX_RegWrite = 1'b1; ID_EX_Dst = 5'd0; IF_ID_Rs = 5'd0;
      expect_cyc("reg_zero_no_stall", 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
   endtask

   task automatic test_branch();
      idle_in();
      IF_ID_Branch = 1'b1; IF_ID_UsesRt = 1'b1; IF_ID_Rt = 5'd7; IF_ID_Rs = 5'd2;
      ID_EX_RegWrite = 1'b1; ID_EX_Dst = 5'd7;
      expect_cyc("br_alu_stall", 1'b0, 1'b1, 1'b0, 2'd2, 1'b0);
      ID_EX_RegWrite = 1'b0; ID_EX_Dst = 5'd0;
      expect_cyc("br_alu_release", 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
      ID_EX_RegWrite = 1'b1; ID_EX_MemRead = 1'b1; ID_EX_Dst = 5'd7;
      expect_cyc("br_load_stall1", 1'b0, 1'b1, 1'b0, 2'd2, 1'b0);
      ID_EX_RegWrite = 1'b0; ID_EX_MemRead = 1'b0; ID_EX_Dst = 5'd0;
      expect_cyc("br_load_stall2", 1'b0, 1'b1, 1'b0, 2'd2, 1'b0);
      expect_cyc("br_load_release", 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
   endtask

   task automatic test_stats();
      n_checks++;
      if (cnt_a !== stat_exp(4)) $display("FAIL stats_after_hazards: got %0d required %0d", cnt_a, stat_exp(4));
      else n_pass++;
   endtask

   task automatic test_branch_flush();
      idle_in();
      IF_ID_Branch = 1'b1; IF_ID_Rs = 5'd7;
      ID_EX_RegWrite = 1'b1; ID_EX_MemRead = 1'b1; ID_EX_Dst = 5'd7;
      expect_cyc("brf_stall1", 1'b0, 1'b1, 1'b0, 2'd2, 1'b0);
      ID_EX_RegWrite = 1'b0; ID_EX_MemRead = 1'b0; ID_EX_Dst = 5'd0; Flush = 1'b1;
      expect_cyc("brf_flush_br_load2", 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
      idle_in();
      expect_cyc("brf_back_idle", 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
   endtask

   task automatic test_rt_sources();
      idle_in();
      ID_EX_MemRead = 1'b1; ID_EX_RegWrite = 1'b1; ID_EX_Dst = 5'd12;
      IF_ID_Rs = 5'd3; IF_ID_Rt = 5'd12; IF_ID_UsesRt = 1'b1;
      expect_cyc("rt_used_stall", 1'b0, 1'b1, 1'b0, 2'd1, 1'b0);
      IF_ID_UsesRt = 1'b0;
      expect_cyc("rt_unused_no_stall", 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
      ID_EX_MemRead = 1'b0; IF_ID_Rs = 5'd12;
      expect_cyc("alu_dep_no_stall", 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
   endtask

   task automatic test_find();
      idle_in();
      IF_ID_Find = 1'b1; IF_ID_Rs = 5'd4;
      expect_cyc("find_go", 1'b0, 1'b0, 1'b1, 2'd0, 1'b1);
      for (int i = 1; i <= 10; i++) begin
         find_done = (i == 10);
         expect_cyc($sformatf("find_busy%0d", i), 1'b0, 1'b1, 1'b0, 2'd3, 1'b0);
      end
      idle_in();
      expect_cyc("find_after_done", 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
      n_checks++;
      if (to_a !== 1'b0) $display("FAIL find_no_timeout: got %b required 0", to_a);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      idle_in();
      ID_EX_MemRead = 1'b1; ID_EX_RegWrite = 1'b1; ID_EX_Dst = 5'd9; IF_ID_Rs = 5'd9;
      IF_ID_Find = 1'b1;
      expect_cyc("b2b_stall_blocks_go", 1'b0, 1'b1, 1'b0, 2'd1, 1'b0);
      ID_EX_MemRead = 1'b0; ID_EX_RegWrite = 1'b0; ID_EX_Dst = 5'd0;
      expect_cyc("b2b_go", 1'b0, 1'b0, 1'b1, 2'd0, 1'b1);
      expect_cyc("b2b_no_consecutive_go", 1'b0, 1'b1, 1'b0, 2'd3, 1'b0);
      IF_ID_Find = 1'b0; find_done = 1'b1;
      expect_cyc("b2b_done", 1'b0, 1'b1, 1'b0, 2'd3, 1'b0);
      idle_in();
      expect_cyc("b2b_idle", 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
   endtask

   task automatic pulse_reset();
      idle_in();
      Reset_n = 1'b0;
      expect_cyc("pulse_reset_b", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
      Reset_n = 1'b1;
   endtask

   task automatic test_find_done_last();
      idle_in();
      IF_ID_Find = 1'b1;
      expect_cyc("fdl_go", 1'b1, 1'b0, 1'b1, 2'd0, 1'b1);
      IF_ID_Find = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         find_done = (i == 4);
         expect_cyc($sformatf("fdl_busy%0d", i), 1'b1, 1'b1, 1'b0, 2'd3, 1'b0);
      end
      idle_in();
      expect_cyc("fdl_idle", 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
      n_checks++;
      if (to_b !== 1'b0) $display("FAIL done_beats_timeout: got %b required 0", to_b);
      else n_pass++;
   endtask

   task automatic test_timeout();
      idle_in();
      IF_ID_Find = 1'b1;
      expect_cyc("to_go", 1'b1, 1'b0, 1'b1, 2'd0, 1'b1);
      IF_ID_Find = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         Flush = (i == 2);
         if (i == 2) expect_cyc("to_flush_busy", 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
         else        expect_cyc($sformatf("to_busy%0d", i), 1'b1, 1'b1, 1'b0, 2'd3, 1'b0);
      end
      n_checks++;
      if (to_b !== 1'b1) $display("FAIL timeout_set: got %b required 1", to_b);
      else n_pass++;
      idle_in();
      expect_cyc("to_idle", 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
      find_done = 1'b1;
      expect_cyc("to_late_done", 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
      idle_in();
      expect_cyc("to_idle2", 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
      n_checks++;
      if (to_b !== 1'b1) $display("FAIL timeout_sticky: got %b required 1", to_b);
      else n_pass++;
   endtask

   task automatic test_reset_mid_find();
      idle_in();
      IF_ID_Find = 1'b1;
      expect_cyc("rmf_go", 1'b1, 1'b0, 1'b1, 2'd0, 1'b1);
      IF_ID_Find = 1'b0;
      expect_cyc("rmf_busy1", 1'b1, 1'b1, 1'b0, 2'd3, 1'b0);
      expect_cyc("rmf_busy2", 1'b1, 1'b1, 1'b0, 2'd3, 1'b0);
      Reset_n = 1'b0;
      expect_cyc("rmf_in_reset", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
      n_checks++;
      if (to_b !== 1'b0) $display("FAIL rmf_timeout_cleared: got %b required 0", to_b);
      else n_pass++;
      n_checks++;
      if (cnt_b !== 16'd0) $display("FAIL rmf_count_cleared: got %0d required 0", cnt_b);
      else n_pass++;
      Reset_n = 1'b1;
      find_done = 1'b1;
      expect_cyc("rmf_late_done", 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
      idle_in();
      expect_cyc("rmf_idle", 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
   endtask

   task automatic test_stats_clr();
      idle_in();
      ID_EX_MemRead = 1'b1; ID_EX_RegWrite = 1'b1; ID_EX_Dst = 5'd5; IF_ID_Rs = 5'd5;
      expect_cyc("clr_pre_stall", 1'b0, 1'b1, 1'b0, 2'd1, 1'b0);
      n_checks++;
      if (cnt_a !== stat_exp(1)) $display("FAIL stats_pre_clr: got %0d required %0d", cnt_a, stat_exp(1));
      else n_pass++;
      stats_clr = 1'b1;
      expect_cyc("clr_stall", 1'b0, 1'b1, 1'b0, 2'd1, 1'b0);
      n_checks++;
      if (cnt_a !== 16'd0) $display("FAIL stats_clr_wins: got %0d required 0", cnt_a);
      else n_pass++;
      stats_clr = 1'b0;
      expect_cyc("clr_post_stall", 1'b0, 1'b1, 1'b0, 2'd1, 1'b0);
      idle_in();
      expect_cyc("clr_idle", 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
      n_checks++;
      if (cnt_a !== stat_exp(1)) $display("FAIL stats_post_clr: got %0d required %0d", cnt_a, stat_exp(1));
      else n_pass++;
   endtask

   initial begin
      Reset_n = 1'b0;
      idle_in();
      @(posedge Clk);
      #1;
      test_reset();
      test_load_use();
      test_reg_zero();
      test_branch();
      test_stats();
      test_branch_flush();
      test_rt_sources();
      test_find();
      test_back_to_back();
      pulse_reset();
      test_find_done_last();
      test_timeout();
      test_reset_mid_find();
      test_stats_clr();
      @(negedge Clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
